// File: rtl/qft3_spi_host_master.sv
// qft3_spi_host_master: mode-0 SPI initiator that writes NUM_WORDS words, waits GAP_CYCLES, then reads NUM_WORDS words.
// Unstalled frame: 2*BITS*2*CLK_DIV + 2*CLK_DIV + NUM_WORDS + GAP_CYCLES + 1 cycles from start acceptance to the end of done (2141 at defaults).
module qft3_spi_host_master #(
    parameter int TOTAL_WIDTH = 16,
    parameter int NUM_WORDS   = 16,
    parameter int CLK_DIV     = 2,
    parameter int GAP_CYCLES  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [TOTAL_WIDTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [TOTAL_WIDTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   sclk,
    output logic                   cs,
    output logic                   mosi,
    input  logic                   miso
);
    localparam int BW = TOTAL_WIDTH > 1 ? $clog2(TOTAL_WIDTH) : 1;
    localparam int NW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    localparam int CW = $clog2(GAP_CYCLES > 2 * CLK_DIV ? GAP_CYCLES : 2 * CLK_DIV);

    typedef enum logic [3:0] {
        IDLE, WR_CMD, WR_LOAD, WR_SHIFT, WR_END, GAP, RD_CMD, RD_SHIFT, RD_END, DONE
    } state_t;

    state_t state, state_d;
    logic [CW-1:0] cnt;
    logic [BW-1:0] b;
    logic [NW-1:0] w;
    logic [TOTAL_WIDTH-1:0] sh, rsh;
    logic in_bit, shifting, rise, fall, last_bit, last_word, load, hold_done;

    always_comb begin
        in_bit    = state inside {WR_CMD, WR_SHIFT, RD_CMD, RD_SHIFT};
        shifting  = state inside {WR_SHIFT, RD_SHIFT};
        rise      = in_bit && cnt == CW'(CLK_DIV - 1);
        fall      = in_bit && cnt == CW'(2 * CLK_DIV - 1);
        hold_done = cnt == CW'(CLK_DIV - 1);
        last_bit  = b == BW'(TOTAL_WIDTH - 1);
        last_word = w == NW'(NUM_WORDS - 1);
        load      = state == WR_LOAD && tx_valid;
        tx_ready  = state == WR_LOAD;
        busy      = !(state inside {IDLE, DONE});
        done      = state == DONE;
        state_d   = state;
        case (state)
            IDLE:     state_d = start ? WR_CMD : IDLE;
            WR_CMD:   state_d = fall ? WR_LOAD : WR_CMD;
            WR_LOAD:  state_d = tx_valid ? WR_SHIFT : WR_LOAD;
            WR_SHIFT: state_d = fall && last_bit ? (last_word ? WR_END : WR_LOAD) : WR_SHIFT;
            WR_END:   state_d = hold_done ? GAP : WR_END;
            GAP:      state_d = cnt == CW'(GAP_CYCLES - 1) ? RD_CMD : GAP;
            RD_CMD:   state_d = fall ? RD_SHIFT : RD_CMD;
            RD_SHIFT: state_d = fall && last_bit && last_word ? RD_END : RD_SHIFT;
            RD_END:   state_d = hold_done ? DONE : RD_END;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // cnt doubles as the sclk phase counter inside a bit and as the hold/gap timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            b        <= '0;
            w        <= '0;
            sh       <= '0;
            rsh      <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            sclk     <= 1'b0;
            cs       <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            cnt      <= (state_d != state || fall || !(in_bit || state inside {WR_END, GAP, RD_END})) ? '0 : cnt + CW'(1);
            b        <= shifting && fall ? (last_bit ? '0 : b + BW'(1)) : b;
            w        <= shifting && fall && last_bit ? (last_word ? '0 : w + NW'(1)) : w;
            sh       <= load ? tx_data : (state == WR_SHIFT && fall) ? sh << 1 : sh;
            rsh      <= state == RD_SHIFT && rise ? {rsh[TOTAL_WIDTH-2:0], miso} : rsh;
            rx_valid <= state == RD_SHIFT && rise && last_bit;
            rx_data  <= state == RD_SHIFT && rise && last_bit ? {rsh[TOTAL_WIDTH-2:0], miso} : rx_data;
            sclk     <= rise || (sclk && !fall);
            cs       <= state_d inside {IDLE, GAP, DONE};
            mosi     <= state_d == WR_CMD ? 1'b1 :
                        load ? tx_data[TOTAL_WIDTH-1] :
                        (state == WR_SHIFT && fall && !last_bit) ? sh[TOTAL_WIDTH-2] :
                        state_d inside {WR_LOAD, WR_SHIFT} ? mosi : 1'b0;
        end
    end
endmodule
